debug_trace_tx: RTL

Serialises a snapshot of the pipelined CPU's debug observation words (instruction address, x31, load register data, EX/MEM data address, MEM/WB read data) onto a UART 8N1 line. It gives the board a trace path that needs no VIO/ILA cores. It sits beside `pipeline_CPU` in the top level, on the free-running board clock. A single-cycle capture strobe, typically one per stepped CPU clock, latches all five words and streams them out as one framed packet.

---
 rtl/debug_trace_tx_if.sv | 24 ++
 rtl/debug_trace_tx.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/debug_trace_tx_if.sv
// Capture/snapshot/UART bundle between the debug trace serialiser and its driver.
// master drives the capture strobe and observation words; slave is debug_trace_tx.
interface debug_trace_tx_if;
    logic        capture;
    logic [31:0] w0_iaddr;
    logic [31:0] w1_x31;
    logic [31:0] w2_regdata;
    logic [31:0] w3_daddr;
    logic [31:0] w4_drdata;
    logic        tx;
    logic        ready;
    logic        frame_done;
    logic [7:0]  drop_count;

    modport master (
        output capture, w0_iaddr, w1_x31, w2_regdata, w3_daddr, w4_drdata,
        input  tx, ready, frame_done, drop_count
    );

    modport slave (
        input  capture, w0_iaddr, w1_x31, w2_regdata, w3_daddr, w4_drdata,
        output tx, ready, frame_done, drop_count
    );
endinterface

// File: rtl/debug_trace_tx.sv
// UART 8N1 serialiser for a five-word CPU debug snapshot: sync 0xA5, 20 big-endian data bytes,
// plus an XOR checksum byte when DEBUG_TRACE_CHECKSUM_EN is defined.
module debug_trace_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic           clk,
    input  logic           reset,
    debug_trace_tx_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

`ifdef DEBUG_TRACE_CHECKSUM_EN
    localparam logic [4:0] LAST_BYTE = 5'd21;
`else
    localparam logic [4:0] LAST_BYTE = 5'd20;
`endif

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    logic [1:0]   state;
    logic [15:0]  bit_timer;
    logic [2:0]   bit_idx;
    logic [4:0]   byte_idx;
    logic [159:0] snapshot;
    logic [7:0]   shift_reg;
    logic         tx_r;
    logic         frame_done_r;
    logic [7:0]   drop_count_r;
    logic [7:0]   cur_byte;
    logic         bit_end;

`ifdef DEBUG_TRACE_CHECKSUM_EN
    logic [7:0] checksum;

    always_comb begin
        checksum = 8'h00;
        for (int i = 0; i < 20; i++) begin
            checksum = checksum ^ snapshot[159 - 8*i -: 8];
        end
    end
`endif

    // Byte 0 is the sync marker; bytes 1..20 walk the snapshot from its top byte down.
    always_comb begin
        cur_byte = 8'hA5;
        for (int i = 0; i < 20; i++) begin
            if (byte_idx == 5'(i + 1)) begin
                cur_byte = snapshot[159 - 8*i -: 8];
            end
        end
`ifdef DEBUG_TRACE_CHECKSUM_EN
        if (byte_idx == LAST_BYTE) begin
            cur_byte = checksum;
        end
`endif
    end

    assign bit_end = (bit_timer == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            bit_timer    <= 16'd0;
            bit_idx      <= 3'd0;
            byte_idx     <= 5'd0;
            snapshot     <= '0;
            shift_reg    <= 8'd0;
            tx_r         <= 1'b1;
            frame_done_r <= 1'b0;
            drop_count_r <= 8'd0;
        end else begin
            frame_done_r <= 1'b0;
            if (bus.capture && (state != S_IDLE) && (drop_count_r != 8'hFF)) begin
                drop_count_r <= drop_count_r + 8'd1;
            end

            case (state)
                S_IDLE: begin
                    if (bus.capture) begin
                        snapshot  <= {bus.w0_iaddr, bus.w1_x31, bus.w2_regdata,
                                      bus.w3_daddr, bus.w4_drdata};
                        state     <= S_START;
                        tx_r      <= 1'b0;
                        bit_timer <= 16'd0;
                        byte_idx  <= 5'd0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        bit_timer <= 16'd0;
                        bit_idx   <= 3'd0;
                        tx_r      <= cur_byte[0];
                        shift_reg <= {1'b0, cur_byte[7:1]};
                        state     <= S_DATA;
                    end else begin
                        bit_timer <= bit_timer + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_timer <= 16'd0;
                        if (bit_idx == 3'd7) begin
                            tx_r  <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            tx_r      <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_timer <= bit_timer + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        bit_timer <= 16'd0;
                        if (byte_idx == LAST_BYTE) begin
                            state        <= S_IDLE;
                            frame_done_r <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 5'd1;
                            tx_r     <= 1'b0;
                            state    <= S_START;
                        end
                    end else begin
                        bit_timer <= bit_timer + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.tx         = tx_r;
    assign bus.ready      = (state == S_IDLE);
    assign bus.frame_done = frame_done_r;
    assign bus.drop_count = drop_count_r;
endmodule
